// File: rtl/expr_lane_pipe.sv
// rtl/expr_lane_pipe.sv - multi-lane mixed-signedness expression evaluator behind an elastic valid/ready pipeline
//
// Purpose:
//   Each transaction carries LANES independent two-operand expressions. Each
//   expression has its own opcode and signed/unsigned mode. All lanes are
//   evaluated combinationally at the input and captured in stage 0. The
//   remaining STAGES-1 register stages only carry the results forward. The
//   results leave as one packed bus, with lane 0 at the LSB.
//
// Optional feature:
//   EXPR_LANE_PIPE_DIV_EN - when defined, op 8 (DIV) and op 9 (MOD) are legal.
//   Otherwise ops 8-15 are illegal and no divider logic is built.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   transaction offered
//   in_ready   transaction can be accepted this cycle
//   op         per-lane opcode, lane i at [4i+3:4i]
//   sgn        per-lane mode, 1 = two's-complement signed operands
//   a, b       per-lane operands, lane i at [W*i+W-1:W*i]
//   out_valid  result available
//   out_ready  consumer accepts the result
//   y          packed per-lane results
//   ovf        sticky per-lane overflow / illegal-op flags
//   clr_ovf    synchronous clear of ovf (a coincident set wins)

module expr_lane_pipe #(
    parameter int LANES  = 6,
    parameter int W      = 6,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*LANES-1:0]   op,
    input  logic [LANES-1:0]     sgn,
    input  logic [W*LANES-1:0]   a,
    input  logic [W*LANES-1:0]   b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W*LANES-1:0]   y,
    output logic [LANES-1:0]     ovf,
    input  logic                 clr_ovf
);

    localparam int DW   = W * LANES;
    // The shift amount is b[clog2(W):0]. This field is always wide enough to
    // encode W itself, so "shift >= W" can be detected directly.
    localparam int SH_W = $clog2(W) + 1;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_LT   = 4'd6;
    localparam logic [3:0] OP_REDX = 4'd7;
`ifdef EXPR_LANE_PIPE_DIV_EN
    localparam logic [3:0] OP_DIV  = 4'd8;
    localparam logic [3:0] OP_MOD  = 4'd9;
`endif

    // Evaluate a single lane. The return value is {error_flag, result[W-1:0]}.
    function automatic logic [W:0] eval_lane(
        input logic [3:0]   o,
        input logic         s,
        input logic [W-1:0] x,
        input logic [W-1:0] z
    );
        logic [W:0]      wide;
        logic [W-1:0]    r;
        logic            e;
        logic [SH_W-1:0] sh;
        logic            big;
        logic            lt;
`ifdef EXPR_LANE_PIPE_DIV_EN
        logic [W-1:0]    minv;
        logic [W-1:0]    q;
        logic [W-1:0]    m;
`endif
        wide = '0;
        r    = '0;
        e    = 1'b0;
        sh   = z[SH_W-1:0];
        big  = (sh >= SH_W'(W));
        lt   = s ? ($signed(x) < $signed(z)) : (x < z);
`ifdef EXPR_LANE_PIPE_DIV_EN
        minv = {1'b1, {(W-1){1'b0}}};
        q    = '0;
        m    = '0;
`endif
        case (o)
            OP_ADD: begin
                wide = {1'b0, x} + {1'b0, z};
                r    = wide[W-1:0];
                // Signed overflow: like-signed operands produce an unlike-signed sum.
                e    = s ? ((x[W-1] == z[W-1]) && (r[W-1] != x[W-1])) : wide[W];
            end
            OP_SUB: begin
                wide = {1'b0, x} - {1'b0, z};
                r    = wide[W-1:0];
                // Unsigned mode: the extra MSB is the borrow out.
                e    = s ? ((x[W-1] != z[W-1]) && (r[W-1] != x[W-1])) : wide[W];
            end
            OP_AND: r = x & z;
            OP_XOR: r = x ^ z;
            OP_SHL: r = big ? '0 : (x << sh);
            OP_SHR: begin
                if (s) begin
                    r = big ? {W{x[W-1]}} : W'($signed(x) >>> sh);
                end else begin
                    r = big ? '0 : (x >> sh);
                end
            end
            OP_LT:  r = {{(W-1){1'b0}}, lt};
            OP_REDX: begin
                r[1] = ^x;
                r[0] = ^z;
            end
`ifdef EXPR_LANE_PIPE_DIV_EN
            OP_DIV, OP_MOD: begin
                if (z == '0) begin
                    // Division by zero: DIV returns all ones, MOD returns the dividend.
                    q = '1;
                    m = x;
                    e = 1'b1;
                end else if (s) begin
                    if ((x == minv) && (z == '1)) begin
                        // min / -1 cannot be represented. Only the quotient overflows.
                        q = minv;
                        m = '0;
                        e = (o == OP_DIV);
                    end else begin
                        q = W'($signed(x) / $signed(z));
                        m = W'($signed(x) % $signed(z));
                    end
                end else begin
                    q = x / z;
                    m = x % z;
                end
                r = (o == OP_DIV) ? q : m;
            end
`endif
            default: begin
                r = '0;
                e = 1'b1;
            end
        endcase
        return {e, r};
    endfunction

    // Evaluation of all lanes at the input
    logic [DW-1:0]    eval_y;
    logic [LANES-1:0] eval_err;

    always_comb begin
        eval_y   = '0;
        eval_err = '0;
        for (int l = 0; l < LANES; l++) begin
            {eval_err[l], eval_y[l*W +: W]} =
                eval_lane(op[4*l +: 4], sgn[l], a[l*W +: W], b[l*W +: W]);
        end
    end

    // Elastic pipeline
    // load_x[s] means stage s can take new contents this cycle. Index STAGES
    // stands for the consumer, so a full pipeline still advances as a whole
    // when out_ready is high. There is no bubble: ready ripples
    // combinationally from out_ready back to in_ready.
    logic [STAGES-1:0] v;
    logic [DW-1:0]     d [STAGES];
    logic [STAGES:0]   load_x;
    logic              accept;

    always_comb begin
        load_x         = '0;
        load_x[STAGES] = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            load_x[s] = !v[s] || load_x[s+1];
        end
    end

    assign in_ready  = load_x[0];
    assign accept    = in_valid && load_x[0];
    assign out_valid = v[STAGES-1];
    assign y         = d[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int s = 0; s < STAGES; s++) begin
                d[s] <= '0;
            end
        end else begin
            if (load_x[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    d[0] <= eval_y;
                end
            end
            for (int s = 1; s < STAGES; s++) begin
                if (load_x[s]) begin
                    v[s] <= v[s-1];
                    // Data is only copied along with a valid token, so that
                    // y keeps the last result while the pipe is empty.
                    if (v[s-1]) begin
                        d[s] <= d[s-1];
                    end
                end
            end
        end
    end

    // Sticky flags are set when a transaction is written into stage 0. The
    // set is OR-ed in after the clear, so a coincident set survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= '0;
        end else if (clr_ovf || accept) begin
            ovf <= (clr_ovf ? '0 : ovf) | (accept ? eval_err : '0);
        end
    end

endmodule

// File: tb/tb_expr_lane_pipe.sv
// tb/tb_expr_lane_pipe.sv - directed self-checking bench for expr_lane_pipe

module tb_expr_lane_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] op;
    logic [5:0]  sgn;
    logic [35:0] a;
    logic [35:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] y;
    logic [5:0]  ovf;
    logic        clr_ovf;

    int total;
    int bad;

    expr_lane_pipe #(.LANES(6), .W(6), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .sgn       (sgn),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_lanes();
        op  = '0;
        sgn = '0;
        a   = '0;
        b   = '0;
    endtask

    task automatic set_lane(input int l, input logic [3:0] o, input logic s,
                            input logic [5:0] x, input logic [5:0] z);
        op[4*l +: 4] = o;
        sgn[l]       = s;
        a[6*l +: 6]  = x;
        b[6*l +: 6]  = z;
    endtask

    task automatic clr_pulse();
        @(negedge clk);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        chk("clr_ovf", ovf, 6'b0);
    endtask

    // Send one transaction into an empty pipe and collect it two cycles later.
    // fo holds the flags that are visible right after the accepting edge.
    task automatic run_one(input string tag, output logic [35:0] yo, output logic [5:0] fo);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fo = ovf;
        chk({tag, "_lat1"}, out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk({tag, "_lat2"}, out_valid, 1'b1);
        yo = y;
        @(posedge clk);
        #1;
        chk({tag, "_drain"}, out_valid, 1'b0);
    endtask

    logic [35:0] yo;
    logic [5:0]  fo;
    int          sent;
    int          got;
    int          occ;
    logic        acc;
    logic        con;

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        clear_lanes();

        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_y", y, 36'h0);
        chk("rst_ovf", ovf, 6'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Lane 0 ADD: signed overflow, then the same operands unsigned
        set_lane(0, 4'd0, 1'b1, 6'd31, 6'd1);
        run_one("add_s", yo, fo);
        chk("add_s_y", yo[5:0], 6'h20);
        chk("add_s_ovf", fo, 6'b000001);
        clr_pulse();
        set_lane(0, 4'd0, 1'b0, 6'd31, 6'd1);
        run_one("add_u", yo, fo);
        chk("add_u_y", yo[5:0], 6'h20);
        chk("add_u_ovf", fo, 6'b000000);

        // Unsigned carry and unsigned borrow
        set_lane(0, 4'd0, 1'b0, 6'h3F, 6'h01);
        run_one("add_c", yo, fo);
        chk("add_c_y", yo[5:0], 6'h00);
        chk("add_c_ovf", fo, 6'b000001);
        clr_pulse();
        set_lane(0, 4'd1, 1'b0, 6'h01, 6'h02);
        run_one("sub_b", yo, fo);
        chk("sub_b_y", yo[5:0], 6'h3F);
        chk("sub_b_ovf", fo, 6'b000001);
        clr_pulse();
        clear_lanes();

        // Lane 1 SHR
        set_lane(1, 4'd5, 1'b1, 6'b100000, 6'd1);
        run_one("shr_s", yo, fo);
        chk("shr_s_y", yo[11:6], 6'b110000);
        set_lane(1, 4'd5, 1'b0, 6'b100000, 6'd1);
        run_one("shr_u", yo, fo);
        chk("shr_u_y", yo[11:6], 6'b010000);
        set_lane(1, 4'd5, 1'b1, 6'b100000, 6'd7);
        run_one("shr_big", yo, fo);
        chk("shr_big_y", yo[11:6], 6'b111111);
        chk("shr_ovf", fo, 6'b000000);
        clear_lanes();

        // Lane 2 LT
        set_lane(2, 4'd6, 1'b1, 6'h3F, 6'h01);
        run_one("lt_s", yo, fo);
        chk("lt_s_y", yo[17:12], 6'd1);
        set_lane(2, 4'd6, 1'b0, 6'h3F, 6'h01);
        run_one("lt_u", yo, fo);
        chk("lt_u_y", yo[17:12], 6'd0);
        clear_lanes();

        // All lanes at once: AND, XOR, SHL, SHL by W, REDX, signed SUB overflow
        set_lane(0, 4'd2, 1'b0, 6'h3C, 6'h0F);
        set_lane(1, 4'd3, 1'b0, 6'h3C, 6'h0F);
        set_lane(2, 4'd4, 1'b0, 6'h05, 6'd2);
        set_lane(3, 4'd4, 1'b0, 6'h01, 6'd6);
        set_lane(4, 4'd7, 1'b0, 6'h07, 6'h03);
        set_lane(5, 4'd1, 1'b1, 6'h20, 6'h01);
        run_one("mix", yo, fo);
        chk("mix_y", yo, {6'h1F, 6'h02, 6'h00, 6'h14, 6'h33, 6'h0C});
        chk("mix_ovf", fo, 6'b100000);
        clr_pulse();
        clear_lanes();

        // Illegal opcode on lane 3, then a clear that coincides with a new set
        set_lane(3, 4'd12, 1'b0, 6'd5, 6'd3);
        set_lane(0, 4'd0, 1'b1, 6'd31, 6'd1);
        run_one("ill", yo, fo);
        chk("ill_y", yo[23:18], 6'h00);
        chk("ill_ovf", fo, 6'b001001);
        set_lane(0, 4'd0, 1'b0, 6'd0, 6'd0);
        clr_ovf = 1'b1;
        run_one("clrset", yo, fo);
        clr_ovf = 1'b0;
        chk("clrset_ovf", fo, 6'b001000);
        clr_pulse();
        clear_lanes();

`ifdef EXPR_LANE_PIPE_DIV_EN
        set_lane(4, 4'd8, 1'b1, 6'h39, 6'd2);
        run_one("div", yo, fo);
        chk("div_y", yo[29:24], 6'h3D);
        chk("div_ovf", fo, 6'b000000);
        set_lane(4, 4'd9, 1'b1, 6'h39, 6'd2);
        run_one("mod", yo, fo);
        chk("mod_y", yo[29:24], 6'h3F);
        set_lane(4, 4'd8, 1'b1, 6'h39, 6'd0);
        run_one("div0", yo, fo);
        chk("div0_y", yo[29:24], 6'h3F);
        chk("div0_ovf", fo, 6'b010000);
`else
        set_lane(4, 4'd8, 1'b1, 6'h39, 6'd2);
        run_one("div_ill", yo, fo);
        chk("div_ill_y", yo[29:24], 6'h00);
        chk("div_ill_ovf", fo, 6'b010000);
`endif
        clr_pulse();
        clear_lanes();

        // Back-to-back stream of 10 with out_ready toggling every cycle
        sent = 0;
        got  = 0;
        occ  = 0;
        for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
            @(negedge clk);
            out_ready = (cyc % 2 == 0);
            in_valid  = (sent < 10);
            a[5:0]    = 6'(sent);
            b[5:0]    = 6'd10;
            #1;
            chk("stream_in_ready", in_ready, !(occ == 2 && !out_ready));
            acc = in_valid && in_ready;
            con = out_valid && out_ready;
            if (con) begin
                chk("stream_y", y[5:0], 6'(got + 10));
                got++;
            end
            @(posedge clk);
            if (acc) sent++;
            occ = occ + (acc ? 1 : 0) - (con ? 1 : 0);
        end
        in_valid = 1'b0;
        chk("stream_count", got, 10);
        @(negedge clk);
        #1;
        chk("stream_empty", out_valid, 1'b0);
        clear_lanes();

        // Reset with two transactions in flight
        set_lane(0, 4'd0, 1'b1, 6'd31, 6'd1);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        chk("mid_pre_valid", out_valid, 1'b1);
        chk("mid_pre_ovf", ovf[0], 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_y", y, 36'h0);
        chk("mid_rst_ovf", ovf, 6'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("mid_in_ready", in_ready, 1'b1);
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("mid_no_output", out_valid, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
